instruction_fetch: RTL

Fetch stage that sits directly downstream of ProgramCounter. It consumes `current`, drives ProgramCounter's `mode`/`update`/`update_en`, reads one 32-bit instruction word per PC from the instruction memory bus, and hands it to decode over a valid/ready handshake. It also absorbs redirects (branch/jump targets) from later stages, including discarding a memory response that is already in flight.

---
 rtl/instruction_fetch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage between ProgramCounter and decode
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (adds inst_fault, traps misaligned fetch addresses)
`ifndef XBUS
`define XBUS 31:0
`endif
`ifndef PC_MODE_MSB
`define PC_MODE_MSB 1
`endif
`ifndef PC_MODE_INC
`define PC_MODE_INC 2'b01
`endif
`ifndef PC_MODE_SET
`define PC_MODE_SET 2'b10
`endif

module instruction_fetch #(
  parameter int RESET_HOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [`XBUS]          pc_current,
  output logic [`PC_MODE_MSB:0] pc_mode,
  output logic [`XBUS]          pc_update,
  output logic                  pc_update_en,
  output logic                  mem_req,
  output logic [`XBUS]          mem_addr,
  input  logic                  mem_ack,
  input  logic [`XBUS]          mem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [`XBUS]          inst_data,
  output logic [`XBUS]          inst_pc,
`ifdef IFETCH_MISALIGN_TRAP_EN
  output logic                  inst_fault,
`endif
  input  logic                  redirect,
  input  logic [`XBUS]          redirect_target
);

  typedef enum logic [1:0] {S_HOLDOFF, S_REQ, S_HOLD, S_DROP} state_t;

  state_t       state, state_nxt;
  logic [3:0]   hold_cnt;
  logic         redir;       // redirect that actually takes effect (ignored in HOLDOFF)
  logic         accept;      // decode handshake not voided by a redirect
  logic         capture;     // latch the memory response into the decode slot
  logic         load_addr;   // a new fetch address is being issued
  logic         trap;        // new fetch address is misaligned and must not reach the bus
  logic [`XBUS] load_val;
  logic [`XBUS] fetch_addr;

  assign redir  = redirect && (state != S_HOLDOFF);
  assign accept = (state == S_HOLD) && inst_valid && inst_ready && !redir;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign fetch_addr = load_val;
`else
  // Without the trap the low address bits simply never reach the bus.
  assign fetch_addr = load_val & ~32'd3;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HOLDOFF;
    else        state <= state_nxt;
  end

  // Next-state and next-fetch-address selection
  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    load_val  = '0;
    capture   = 1'b0;
    trap      = 1'b0;
    case (state)
      S_HOLDOFF: begin
        if (hold_cnt == 4'd0) begin
          load_addr = 1'b1;
          load_val  = pc_current;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (redir) begin
          if (mem_ack) begin
            load_addr = 1'b1;
            load_val  = redirect_target;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_DROP;
          end
        end else if (mem_ack) begin
          capture   = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir) begin
          load_addr = 1'b1;
          load_val  = redirect_target;
          state_nxt = S_REQ;
        end else if (accept) begin
          // PC increments on this same edge, so pc_current+4 is the new PC
          load_addr = 1'b1;
          load_val  = pc_current + 32'd4;
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // Wait out the stale request; a redirect meeting the ack goes straight to its target
        if (mem_ack) begin
          load_addr = 1'b1;
          load_val  = redir ? redirect_target : pc_current;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_HOLDOFF;
    endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
    trap = load_addr && (fetch_addr[1:0] != 2'b00);
`endif
    if (trap) state_nxt = S_HOLD;
  end

  // Bus request and ProgramCounter control outputs
  always_comb begin
    mem_req      = (state == S_REQ) || (state == S_DROP);
    pc_update_en = 1'b0;
    pc_mode      = '0;
    pc_update    = '0;
    if (redir) begin
      pc_update_en = 1'b1;
      pc_mode      = `PC_MODE_SET;
      pc_update    = redirect_target;
    end else if (accept) begin
      pc_update_en = 1'b1;
      pc_mode      = `PC_MODE_INC;
    end
  end

  // Holdoff counter, fetch address and decode slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= 4'(RESET_HOLD);
      mem_addr   <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      inst_fault <= 1'b0;
`endif
    end else begin
      if ((state == S_HOLDOFF) && (hold_cnt != 4'd0)) hold_cnt <= hold_cnt - 4'd1;
      if (load_addr) mem_addr <= fetch_addr;
      if (redir || accept) begin
        inst_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
        inst_fault <= 1'b0;
`endif
      end
      if (capture) begin
        inst_valid <= 1'b1;
        inst_data  <= mem_rdata;
        inst_pc    <= mem_addr;
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (trap) begin
        inst_valid <= 1'b1;
        inst_fault <= 1'b1;
        inst_data  <= '0;
        inst_pc    <= fetch_addr;
      end
`endif
    end
  end

endmodule
